count_seq_checker: RTL and testbench
====================================

// Module: count_seq_checker
// PURPOSE
//  Downstream monitor for the 3-bit skip counter.
//  - Legal cycle: 000->001->010->100->101->110->000. Codes 011 and 111 are illegal.
//  - Locks onto the counter's state bus and checks every sampled transition.
//  - Reports the current phase as one-hot, counts complete cycles, and flags
//    illegal codes and sequence breaks with sticky error bits.
//  - Sits between the counter and the phase-decode/status logic.
// PARAMETERS
//  CW      8  width of the completed-cycle counter (wraps)
//  EW      4  width of the error counter (saturates)
//  RESYNC  1  1: FAULT re-locks on the next 000; 0: FAULT holds until clr_err
// PORTS
//  clk       in   1     rising-edge clock
//  reset     in   1     synchronous, active-high reset
//  a         in   3     counter state bus
//  en        in   1     sample strobe; a is checked only when en=1
//  clr_err   in   1     synchronous clear of err flags, err_cnt, cycle_cnt
//  phase     out  6     registered one-hot phase; bit i = legal index i (000,001,010,100,101,110 -> 0..5)
//  locked    out  1     1 while FSM is in TRACK
//  cycle_cnt out  CW    completed full cycles since lock or clear
//  err_ill   out  1     sticky: illegal code (011/111) sampled
//  err_seq   out  1     sticky: legal code sampled out of order
//  err_cnt   out  EW    saturating count of error events
// BEHAVIOUR
//  - Reset: FSM=IDLE; all outputs 0; internal exp=000.
//  - Timing: all outputs registered. An en=1 sample at edge N is reflected after edge N.
//  - en=0: no state, counter or flag change; phase holds.
//  - FSM states:
//    - IDLE: en & a==000 -> TRACK, exp=001, phase=000001. Any other sample stays IDLE (no error).
//    - TRACK, en & a==exp:
//      - exp=next(a); phase=onehot(idx(a)).
//      - If a==000 (wrap from 110), cycle_cnt++ with modulo-2^CW wrap.
//    - TRACK, en & a!=exp:
//      - -> FAULT; phase=0; err_cnt++ (saturate at 2^EW-1).
//      - a in {011,111}: err_ill=1. Otherwise err_seq=1.
//      - A held value (a==previous) is a mismatch.
//    - FAULT, RESYNC=1: en & a==000 -> TRACK, exp=001, phase=000001; cycle_cnt is not incremented.
//      Other samples stay in FAULT and raise no further errors.
//    - FAULT, RESYNC=0: stays in FAULT until clr_err, then -> IDLE.
//  - locked=1 only in TRACK. phase is always 0 outside TRACK.
//  - clr_err:
//    - Clears err_ill, err_seq, err_cnt and cycle_cnt.
//    - Same cycle as a new error: the clear applies first, then the new error sets its flag; err_cnt=1.
//    - Same cycle as a cycle wrap: cycle_cnt=1.
//  - reset overrides clr_err and en. Reset mid-cycle returns to IDLE; re-lock waits for 000.
//  - next(): 000->001, 001->010, 010->100, 100->101, 101->110, 110->000. Illegal codes map to 000.
// STRUCTURE
//  - Shared package count_seq_pkg (common with the counter):
//    - state codes S0..S7;
//    - FSM encodings IDLE/TRACK/FAULT;
//    - functions next_state(a), is_legal(a), phase_idx(a).
//  - One sub-module, seq_decode: combinational a -> {legal, next[2:0], onehot[5:0]}.
//  - Top level holds the FSM, exp register and counters.
// TESTING
//  1. reset=1 for 2 clk, en=1, counter free-running -> outputs 0 during reset;
//     locked=1 after first 000; phase walks 1,2,4,8,16,32.
//  2. 3 full cycles from lock -> cycle_cnt=3, no error flags.
//  3. Force a=011 in TRACK -> err_ill=1, err_seq=0, locked=0, phase=0, err_cnt=1.
//     Next 000 -> locked=1 (RESYNC=1).
//  4. Sequence 000,001,100 -> err_seq=1 at the 100 sample. 20 more forced errors with
//     RESYNC between -> err_cnt=15 (EW=4, saturated).
//  5. en low every other cycle with a held -> no errors, checking only on en.
//     clr_err pulsed with a coincident 111 -> err_ill=1, err_cnt=1.
//  6. RESYNC=0, CW=2: error then 000 -> stays FAULT until clr_err -> IDLE.
//     Then 5 cycles -> cycle_cnt=1 (wrapped).

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared definitions for the 3-bit skip counter and its sequence checker:
// state codes, checker FSM encoding and the legal-cycle helper functions.
package count_seq_pkg;

   localparam logic [2:0] S0 = 3'b000;
   localparam logic [2:0] S1 = 3'b001;
   localparam logic [2:0] S2 = 3'b010;
   localparam logic [2:0] S3 = 3'b011;
   localparam logic [2:0] S4 = 3'b100;
   localparam logic [2:0] S5 = 3'b101;
   localparam logic [2:0] S6 = 3'b110;
   localparam logic [2:0] S7 = 3'b111;

   localparam int unsigned NUM_PHASES = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } fsm_t;

   function automatic logic is_legal(input logic [2:0] a);
      return (a != S3) && (a != S7);
   endfunction

   // Illegal codes fall back to S0 so a corrupt bus cannot stall the chain.
   function automatic logic [2:0] next_state(input logic [2:0] a);
      logic [2:0] n;
      case (a)
         S0:      n = S1;
         S1:      n = S2;
         S2:      n = S4;
         S4:      n = S5;
         S5:      n = S6;
         S6:      n = S0;
         default: n = S0;
      endcase
      return n;
   endfunction

   function automatic logic [2:0] phase_idx(input logic [2:0] a);
      logic [2:0] idx;
      case (a)
         S0:      idx = 3'd0;
         S1:      idx = 3'd1;
         S2:      idx = 3'd2;
         S4:      idx = 3'd3;
         S5:      idx = 3'd4;
         S6:      idx = 3'd5;
         default: idx = 3'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/count_seq_checker_seq_decode.sv
// Combinational decode of the counter bus: legality, successor code and
// the one-hot phase that code represents (all zero for illegal codes).
module seq_decode
   import count_seq_pkg::*;
(
   input  logic [2:0] i_a,
   output logic       o_legal,
   output logic [2:0] o_next,
   output logic [5:0] o_onehot
);

   logic w_legal;

   assign w_legal  = is_legal(i_a);
   assign o_legal  = w_legal;
   assign o_next   = next_state(i_a);
   assign o_onehot = w_legal ? (6'(1) << phase_idx(i_a)) : 6'd0;

endmodule

// File: rtl/count_seq_checker.sv
// Monitor for the 3-bit skip counter: locks on 000, follows the legal cycle,
// reports the one-hot phase and completed cycles, and records sticky errors.
module count_seq_checker
   import count_seq_pkg::*;
#(
   parameter int unsigned CW     = 8,
   parameter int unsigned EW     = 4,
   parameter bit          RESYNC = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    a,
   input  logic          en,
   input  logic          clr_err,
   output logic [5:0]    phase,
   output logic          locked,
   output logic [CW-1:0] cycle_cnt,
   output logic          err_ill,
   output logic          err_seq,
   output logic [EW-1:0] err_cnt
);

   fsm_t          r_state;
   logic [2:0]    r_exp;
   logic [5:0]    r_phase;
   logic [CW-1:0] r_cycle;
   logic          r_err_ill;
   logic          r_err_seq;
   logic [EW-1:0] r_err_cnt;

   fsm_t          w_state_nxt;
   logic [2:0]    w_exp_nxt;
   logic [5:0]    w_phase_nxt;
   logic [CW-1:0] w_cycle_base;
   logic [CW-1:0] w_cycle_nxt;
   logic [EW-1:0] w_ecnt_base;
   logic [EW-1:0] w_ecnt_nxt;
   logic          w_ill_nxt;
   logic          w_seq_nxt;

   logic          w_dec_legal;
   logic [2:0]    w_dec_next;
   logic [5:0]    w_dec_onehot;

   seq_decode u_dec (
      .i_a      (a),
      .o_legal  (w_dec_legal),
      .o_next   (w_dec_next),
      .o_onehot (w_dec_onehot)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_exp_nxt    = r_exp;
      w_phase_nxt  = r_phase;
      // The clear is applied first so a coincident event lands on a clean slate.
      w_cycle_base = clr_err ? '0 : r_cycle;
      w_ecnt_base  = clr_err ? '0 : r_err_cnt;
      w_cycle_nxt  = w_cycle_base;
      w_ecnt_nxt   = w_ecnt_base;
      w_ill_nxt    = r_err_ill & ~clr_err;
      w_seq_nxt    = r_err_seq & ~clr_err;

      case (r_state)
         ST_IDLE: begin
            w_phase_nxt = '0;
            if (en && (a == S0)) begin
               w_state_nxt = ST_TRACK;
               w_exp_nxt   = S1;
               w_phase_nxt = 6'b000001;
            end
         end

         ST_TRACK: begin
            if (en) begin
               if (a == r_exp) begin
                  w_exp_nxt   = w_dec_next;
                  w_phase_nxt = w_dec_onehot;
                  // Only the 110->000 step can expect S0 while tracking.
                  if (a == S0) begin
                     w_cycle_nxt = w_cycle_base + CW'(1);
                  end
               end else begin
                  w_state_nxt = ST_FAULT;
                  w_phase_nxt = '0;
                  if (w_ecnt_base != {EW{1'b1}}) begin
                     w_ecnt_nxt = w_ecnt_base + EW'(1);
                  end
                  if (!w_dec_legal) begin
                     w_ill_nxt = 1'b1;
                  end else begin
                     w_seq_nxt = 1'b1;
                  end
               end
            end
         end

         ST_FAULT: begin
            w_phase_nxt = '0;
            if (RESYNC) begin
               if (en && (a == S0)) begin
                  w_state_nxt = ST_TRACK;
                  w_exp_nxt   = S1;
                  w_phase_nxt = 6'b000001;
               end
            end else if (clr_err) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_phase_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_exp     <= S0;
         r_phase   <= '0;
         r_cycle   <= '0;
         r_err_ill <= 1'b0;
         r_err_seq <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_exp     <= w_exp_nxt;
         r_phase   <= w_phase_nxt;
         r_cycle   <= w_cycle_nxt;
         r_err_ill <= w_ill_nxt;
         r_err_seq <= w_seq_nxt;
         r_err_cnt <= w_ecnt_nxt;
      end
   end

   assign phase     = r_phase;
   assign locked    = (r_state == ST_TRACK);
   assign cycle_cnt = r_cycle;
   assign err_ill   = r_err_ill;
   assign err_seq   = r_err_seq;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: two instances (RESYNC=1/CW=8 and RESYNC=0/CW=2)
// share one stimulus stream and are compared against a behavioural model.
module tb_count_seq_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       clr_err = 1'b0;
   logic [2:0] a = 3'b000;

   logic [5:0] phase0, phase1;
   logic       locked0, locked1;
   logic [7:0] cyc0;
   logic [1:0] cyc1;
   logic       ill0, ill1, seq0, seq1;
   logic [3:0] ecnt0, ecnt1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   count_seq_checker #(.CW(8), .EW(4), .RESYNC(1'b1)) u0 (
      .clk(clk), .reset(reset), .a(a), .en(en), .clr_err(clr_err),
      .phase(phase0), .locked(locked0), .cycle_cnt(cyc0),
      .err_ill(ill0), .err_seq(seq0), .err_cnt(ecnt0)
   );

   count_seq_checker #(.CW(2), .EW(4), .RESYNC(1'b0)) u1 (
      .clk(clk), .reset(reset), .a(a), .en(en), .clr_err(clr_err),
      .phase(phase1), .locked(locked1), .cycle_cnt(cyc1),
      .err_ill(ill1), .err_seq(seq1), .err_cnt(ecnt1)
   );

   // Reference model: position in the legal cycle, not an encoded FSM.
   int LEG [6] = '{0, 1, 2, 4, 5, 6};
   int m_cw [2] = '{8, 2};
   bit m_rs [2] = '{1'b1, 1'b0};
   bit m_track [2];
   bit m_fault [2];
   int m_exp_pos [2];
   int m_phase [2];
   int m_cyc [2];
   int m_ecnt [2];
   bit m_ill [2];
   bit m_seq [2];
   int ci = 3;

   function automatic int code_pos(input logic [2:0] c);
      for (int i = 0; i < 6; i++) if (LEG[i] == int'(c)) return i;
      return -1;
   endfunction

   task automatic model_step(input int k);
      int pos;
      if (reset) begin
         m_track[k] = 0; m_fault[k] = 0; m_exp_pos[k] = 0; m_phase[k] = 0;
         m_cyc[k] = 0; m_ecnt[k] = 0; m_ill[k] = 0; m_seq[k] = 0;
         return;
      end
      if (clr_err) begin
         m_cyc[k] = 0; m_ecnt[k] = 0; m_ill[k] = 0; m_seq[k] = 0;
      end
      pos = code_pos(a);
      if (m_track[k]) begin
         if (en) begin
            if (pos == m_exp_pos[k]) begin
               m_phase[k] = 1 << pos;
               if (pos == 0) m_cyc[k] = (m_cyc[k] + 1) % (1 << m_cw[k]);
               m_exp_pos[k] = (pos + 1) % 6;
            end else begin
               m_track[k] = 0; m_fault[k] = 1; m_phase[k] = 0;
               if (m_ecnt[k] < 15) m_ecnt[k]++;
               if (pos < 0) m_ill[k] = 1; else m_seq[k] = 1;
            end
         end
      end else if (m_fault[k]) begin
         if (m_rs[k]) begin
            if (en && pos == 0) begin
               m_fault[k] = 0; m_track[k] = 1; m_exp_pos[k] = 1; m_phase[k] = 1;
            end
         end else if (clr_err) begin
            m_fault[k] = 0;
         end
      end else if (en && pos == 0) begin
         m_track[k] = 1; m_exp_pos[k] = 1; m_phase[k] = 1;
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check_val("u0.phase",  32'(phase0), 32'(m_phase[0]));
      check_val("u0.locked", 32'(locked0), 32'(m_track[0]));
      check_val("u0.cycle",  32'(cyc0),   32'(m_cyc[0]));
      check_val("u0.ill",    32'(ill0),   32'(m_ill[0]));
      check_val("u0.seq",    32'(seq0),   32'(m_seq[0]));
      check_val("u0.ecnt",   32'(ecnt0),  32'(m_ecnt[0]));
      check_val("u1.phase",  32'(phase1), 32'(m_phase[1]));
      check_val("u1.locked", 32'(locked1), 32'(m_track[1]));
      check_val("u1.cycle",  32'(cyc1),   32'(m_cyc[1]));
      check_val("u1.ill",    32'(ill1),   32'(m_ill[1]));
      check_val("u1.seq",    32'(seq1),   32'(m_seq[1]));
      check_val("u1.ecnt",   32'(ecnt1),  32'(m_ecnt[1]));
   endtask

   task automatic step(input logic [2:0] ia, input logic ien, input logic iclr, input logic irst);
      @(negedge clk);
      a = ia; en = ien; clr_err = iclr; reset = irst;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1 check_all();
   endtask

   task automatic step_cnt();
      step(3'(LEG[ci]), 1'b1, 1'b0, 1'b0);
      ci = (ci + 1) % 6;
   endtask

   initial begin
      // 1: reset with free-running counter, then lock on first 000
      repeat (2) begin
         step(3'(LEG[ci]), 1'b1, 1'b0, 1'b1);
         ci = (ci + 1) % 6;
      end
      check_val("t1.reset_phase", 32'(phase0), 32'd0);
      while (LEG[ci] != 0) step_cnt();
      step_cnt();
      check_val("t1.locked", 32'(locked0), 32'd1);
      check_val("t1.phase0", 32'(phase0), 32'd1);
      // 2: three full cycles from lock
      repeat (18) step_cnt();
      check_val("t2.cycle", 32'(cyc0), 32'd3);
      check_val("t2.noerr", 32'({ill0, seq0}), 32'd0);
      // 3: illegal code while tracking, then resync
      step(3'b011, 1'b1, 1'b0, 1'b0);
      check_val("t3.ill", 32'(ill0), 32'd1);
      check_val("t3.seq", 32'(seq0), 32'd0);
      check_val("t3.locked", 32'(locked0), 32'd0);
      check_val("t3.ecnt", 32'(ecnt0), 32'd1);
      step(3'b000, 1'b1, 1'b0, 1'b0);
      check_val("t3.relock", 32'(locked0), 32'd1);
      // 4: out-of-order legal code, then saturate the error counter
      step(3'b001, 1'b1, 1'b0, 1'b0);
      step(3'b100, 1'b1, 1'b0, 1'b0);
      check_val("t4.seq", 32'(seq0), 32'd1);
      repeat (20) begin
         step(3'b000, 1'b1, 1'b0, 1'b0);
         step(3'b101, 1'b1, 1'b0, 1'b0);
      end
      check_val("t4.sat", 32'(ecnt0), 32'd15);
      // 5: clear, then en toggling with a held on disabled cycles
      step(3'b000, 1'b1, 1'b1, 1'b0);
      ci = 1;
      repeat (12) begin
         step(3'(LEG[ci]), 1'b1, 1'b0, 1'b0);
         step(3'(LEG[ci]), 1'b0, 1'b0, 1'b0);
         ci = (ci + 1) % 6;
      end
      check_val("t5.noerr", 32'(ecnt0), 32'd0);
      step(3'b111, 1'b1, 1'b1, 1'b0);
      check_val("t5.ill", 32'(ill0), 32'd1);
      check_val("t5.ecnt", 32'(ecnt0), 32'd1);
      // 6: RESYNC=0 instance holds FAULT until clear, cycle count wraps at CW=2
      step(3'b000, 1'b1, 1'b0, 1'b0);
      check_val("t6.fault_hold", 32'(locked1), 32'd0);
      step(3'b000, 1'b0, 1'b1, 1'b0);
      check_val("t6.idle", 32'(locked1), 32'd0);
      ci = 0;
      repeat (31) step_cnt();
      check_val("t6.wrap", 32'(cyc1), 32'd1);
      // Random: mostly a well-behaved counter with sporadic faults
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [2:0] ra;
         logic ren, rclr, rrst;
         r = $urandom_range(0, 99);
         rrst = (r < 2);
         rclr = (r >= 8 && r < 11);
         ren = ($urandom_range(0, 3) != 0);
         ra = (r >= 2 && r < 8) ? 3'($urandom_range(0, 7)) : 3'(LEG[ci]);
         step(ra, ren, rclr, rrst);
         if (ren) ci = (ci + 1) % 6;
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
